usb_rx_nrzi_unstuff: RTL
========================

Name: usb_rx_nrzi_unstuff

Overview:
Receive-side counterpart of the TX bit stuffer. It takes per-bit line samples from the RX line-state/DPPL front end, NRZI-decodes them and removes stuffed zeros. It also detects bit-stuff violations and the SE0-SE0-J end-of-packet sequence. Its output feeds the RX byte/packet assembler as a strobed serial bit stream.

Parameters:
MAX_ONES, 6, number of consecutive decoded ones after which a stuffed zero is mandatory (range 1..7; the counter is 3 bits).

Ports:
clk12  input  1  12 MHz system clock
RST  input  1  asynchronous, active-low reset
rxEN  input  1  receive enable; low forces IDLE and clears all history
rxBitValid  input  1  one-cycle strobe per received bit time; the other inputs are sampled only when it is high
rxLevel  input  1  differential line level (1=J, 0=K); ignored when rxSE0=1
rxSE0  input  1  single-ended-zero line state for this bit
dataValid  output  1  one-cycle pulse: dataOut holds a decoded, unstuffed bit
dataOut  output  1  decoded bit; 0 whenever dataValid=0
eopDetected  output  1  one-cycle pulse on a valid SE0,SE0,J sequence
stuffErr  output  1  one-cycle pulse on a bit-stuff violation
eopErr  output  1  one-cycle pulse on a malformed EOP
busy  output  1  high in RECEIVE, SE0_1 and SE0_2

Behaviour:
- Reset (RST=0, async):
  - state=IDLE, prevLevel=1 (J), oneCounter=0.
  - All outputs are 0.
- Output timing: all outputs are registered. Latency is 1 cycle from the accepted strobe, and pulses last exactly 1 cycle.
- Priority rules:
  - rxEN=0 overrides everything in the same cycle: state goes to IDLE, prevLevel=1, oneCounter=0, and no pulses are produced (a strobe in that cycle is dropped).
  - Without a strobe, nothing changes.
- NRZI decode: decoded = (rxLevel == prevLevel). prevLevel <= rxLevel on every accepted non-SE0 strobe.
- States:
  - IDLE: move to RECEIVE when rxEN=1 (same edge; a strobe in that cycle is processed as RECEIVE).
  - RECEIVE, non-SE0 strobe:
    - If oneCounter==MAX_ONES and decoded=0: stuffed bit. Drop it (no dataValid) and set oneCounter<=0.
    - If oneCounter==MAX_ONES and decoded=1: pulse stuffErr and go to ERROR.
    - Otherwise: pulse dataValid with dataOut=decoded. oneCounter <= decoded ? oneCounter+1 : 0.
  - RECEIVE, SE0 strobe: go to SE0_1. No dataValid; oneCounter and prevLevel are held.
  - SE0_1: SE0 goes to SE0_2. Non-SE0 pulses eopErr and goes to ERROR.
  - SE0_2:
    - Non-SE0 with rxLevel=1 pulses eopDetected and goes to DONE.
    - Non-SE0 with rxLevel=0 pulses eopErr and goes to ERROR.
    - SE0 pulses eopErr and goes to ERROR.
  - DONE and ERROR: ignore strobes and hold until rxEN=0.
- Boundary conditions:
  - Stuffing counts ones across the SYNC pattern; the trailing 1 of SYNC is counted.
  - A stuffed zero immediately before SE0 is removed normally.
  - SE0 arriving with oneCounter==MAX_ONES is not a stuff error (dribble tolerated).
  - rxEN asserted mid-packet starts decode with prevLevel=J.
  - Reset asserted mid-operation returns to reset values immediately.

Decomposition:
- Package usb_rx_pkg holds:
  - state enum (IDLE, RECEIVE, SE0_1, SE0_2, DONE, ERROR)
  - USB_MAX_ONES=6
  - J/K level constants, shared with the TX stuffer/NRZI encoder.
- One natural sub-module: usb_nrzi_decoder (prevLevel register plus XNOR, with load/clear). The FSM, counter and output registers stay in the top module.

Test Plan:
- SYNC: after reset, rxEN=1, levels K,J,K,J,K,J,K,K -> 8 dataValid pulses, dataOut 0,0,0,0,0,0,0,1, busy=1, no errors.
- Stuffed zero: from fresh enable (prev=J), levels J×6 then K then K -> 6 pulses with 1, K dropped (no pulse), next K gives a pulse with 1, oneCounter=1.
- Stuff violation: levels J×7 -> 6 pulses with 1, stuffErr pulse on the 7th bit, no further dataValid even with more strobes, busy=0; rxEN low then high -> normal decode resumes.
- EOP: after SYNC, SE0,SE0,J -> no dataValid for these 3 strobes, eopDetected pulse 1 cycle after the J strobe, busy=0.
- Bad EOP: SE0,K -> eopErr. Separately SE0,SE0,SE0 -> eopErr on the third strobe. Both end in ERROR.
- Async reset mid-packet, and rxEN=0 in the same cycle as rxBitValid -> sample dropped, all outputs 0, state IDLE, prevLevel=J.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive path: FSM states, the bit-stuffing
// limit and the J/K line-level encoding used by both the TX and RX sides.
package usb_rx_pkg;

  // Decoded ones allowed in a row before a stuffed zero must follow.
  localparam int unsigned USB_MAX_ONES = 6;
  // Width of the consecutive-ones counter.
  localparam int unsigned CNT_W = 3;

  // Differential line levels.
  localparam logic LEVEL_J = 1'b1;
  localparam logic LEVEL_K = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    SE0_1,
    SE0_2,
    DONE,
    ERROR
  } rx_state_e;

  // States in which a packet is being received.
  function automatic logic is_busy(input rx_state_e s);
    return (s == RECEIVE) || (s == SE0_1) || (s == SE0_2);
  endfunction

endpackage

// File: rtl/usb_nrzi_decoder.sv
// NRZI decoder: holds the previous line level and reports whether the
// current level matches it (no transition = 1, transition = 0).
// Ports: clk, rst_n (async active-low), clear (back to J), load (capture
// level), level (current line level), decoded_c (combinational decode).
module usb_nrzi_decoder
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic level,
  output logic decoded_c
);

  logic prev_level;

  // Previous-level register; idle line is J.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_level <= LEVEL_J;
    end else if (clear) begin
      prev_level <= LEVEL_J;
    end else if (load) begin
      prev_level <= level;
    end
  end

  assign decoded_c = ~(level ^ prev_level);

endmodule

// File: rtl/usb_rx_nrzi_unstuff.sv
// USB receive NRZI decoder and bit unstuffer with EOP / stuff-error detection.
// Ports:
//   clk12, RST            clock and async active-low reset
//   rxEN                  receive enable (low returns to IDLE, clears history)
//   rxBitValid            per-bit strobe qualifying rxLevel / rxSE0
//   rxLevel, rxSE0        line level (1=J) and single-ended-zero flag
//   dataValid, dataOut    strobed decoded, unstuffed bit stream
//   eopDetected           pulse on SE0,SE0,J
//   stuffErr, eopErr      pulses on stuffing violation / malformed EOP
//   busy                  high while a packet is being received
module usb_rx_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int unsigned MAX_ONES = USB_MAX_ONES
) (
  input  logic clk12,
  input  logic RST,
  input  logic rxEN,
  input  logic rxBitValid,
  input  logic rxLevel,
  input  logic rxSE0,
  output logic dataValid,
  output logic dataOut,
  output logic eopDetected,
  output logic stuffErr,
  output logic eopErr,
  output logic busy
);

  rx_state_e        state, state_nxt, state_cur;
  logic [CNT_W-1:0] one_cnt, cnt_nxt;
  logic             dv_nxt, dout_nxt, eop_nxt, serr_nxt, eerr_nxt, busy_nxt;
  logic             dec_load, dec_clear, decoded;

  usb_nrzi_decoder u_nrzi (
    .clk       (clk12),
    .rst_n     (RST),
    .clear     (dec_clear),
    .load      (dec_load),
    .level     (rxLevel),
    .decoded_c (decoded)
  );

  // State, counter and output registers.
  always_ff @(posedge clk12 or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      one_cnt     <= '0;
      dataValid   <= 1'b0;
      dataOut     <= 1'b0;
      eopDetected <= 1'b0;
      stuffErr    <= 1'b0;
      eopErr      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      one_cnt     <= cnt_nxt;
      dataValid   <= dv_nxt;
      dataOut     <= dout_nxt;
      eopDetected <= eop_nxt;
      stuffErr    <= serr_nxt;
      eopErr      <= eerr_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state, counter and pulse logic.
  always_comb begin
    state_nxt = state;
    state_cur = state;
    cnt_nxt   = one_cnt;
    dv_nxt    = 1'b0;
    dout_nxt  = 1'b0;
    eop_nxt   = 1'b0;
    serr_nxt  = 1'b0;
    eerr_nxt  = 1'b0;
    dec_load  = 1'b0;
    dec_clear = 1'b0;

    if (!rxEN) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      dec_clear = 1'b1;
    end else begin
      // IDLE hands over to RECEIVE on the same edge, so a strobe arriving
      // with the enable is decoded rather than lost.
      state_cur = (state == IDLE) ? RECEIVE : state;
      state_nxt = state_cur;
      if (rxBitValid) begin
        case (state_cur)
          RECEIVE: begin
            if (rxSE0) begin
              // Counter is held: a pending stuffed zero before SE0 is dribble.
              state_nxt = SE0_1;
            end else begin
              dec_load = 1'b1;
              if (one_cnt == CNT_W'(MAX_ONES)) begin
                if (decoded) begin
                  serr_nxt  = 1'b1;
                  state_nxt = ERROR;
                end else begin
                  cnt_nxt = '0;
                end
              end else begin
                dv_nxt   = 1'b1;
                dout_nxt = decoded;
                cnt_nxt  = decoded ? one_cnt + CNT_W'(1) : '0;
              end
            end
          end
          SE0_1: begin
            if (rxSE0) begin
              state_nxt = SE0_2;
            end else begin
              dec_load  = 1'b1;
              eerr_nxt  = 1'b1;
              state_nxt = ERROR;
            end
          end
          SE0_2: begin
            if (!rxSE0 && (rxLevel == LEVEL_J)) begin
              dec_load  = 1'b1;
              eop_nxt   = 1'b1;
              state_nxt = DONE;
            end else begin
              dec_load  = !rxSE0;
              eerr_nxt  = 1'b1;
              state_nxt = ERROR;
            end
          end
          default: begin
            // DONE / ERROR hold until the enable drops.
          end
        endcase
      end
    end

    busy_nxt = is_busy(state_nxt);
  end

endmodule
